// File: rtl/bmp_stream_parser.sv
// BMP byte-stream parser: validates a 24-bit uncompressed BMP header, skips to
// the pixel data, and emits {R,G,B} framebuffer writes in raster order.
// Optional build macro BMP_TOPDOWN_EN: also accept top-down files (height = -V_ACTIVE).
//
// state   | meaning
// S_HDR   | capturing header bytes 0..53
// S_CHECK | one-cycle header validation
// S_SKIP  | discarding bytes up to the pixel-data offset
// S_PIX   | assembling B,G,R bytes into pixels
// S_PAD   | discarding row padding bytes
// S_DONE  | frame complete, terminal until reset
// S_ERR   | header rejected, terminal until reset
module bmp_stream_parser #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  pix_we,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  output logic [23:0]           pix_data,
  output logic                  hdr_ok,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            err_code
);

  localparam int PAD = (4 - ((3 * H_ACTIVE) % 4)) % 4;
  localparam bit HAS_PAD = (PAD != 0);
  localparam logic [1:0] PAD_LAST = 2'((PAD + 3) % 4);
  localparam logic [ADDR_WIDTH-1:0] H_STEP      = ADDR_WIDTH'(H_ACTIVE);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST    = ADDR_WIDTH'(H_ACTIVE - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST    = ADDR_WIDTH'(V_ACTIVE - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_BOTTOM = ADDR_WIDTH'((V_ACTIVE - 1) * H_ACTIVE);

  typedef enum logic [2:0] {
    S_HDR, S_CHECK, S_SKIP, S_PIX, S_PAD, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] sig_q, sig_d, bpp_q, bpp_d;
  logic [31:0] offset_q, offset_d, width_q, width_d, height_q, height_d, comp_q, comp_d;
  logic [1:0]  phase_q, phase_d, pad_cnt_q, pad_cnt_d;
  logic [7:0]  b_q, b_d, g_q, g_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d, row_cnt_q, row_cnt_d, row_base_q, row_base_d;
  logic                  pix_we_q, pix_we_d, hdr_ok_q, hdr_ok_d, done_q, done_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] pix_addr_q, pix_addr_d;
  logic [23:0]           pix_data_q, pix_data_d;
  logic [2:0]            err_code_q, err_code_d;
  logic                  height_ok;
  logic                  topdown_q, topdown_d;

`ifdef BMP_TOPDOWN_EN
  assign height_ok = (height_q == 32'(V_ACTIVE)) || (height_q == 32'(-V_ACTIVE));
`else
  assign height_ok = (height_q == 32'(V_ACTIVE));
`endif

  // Next-state, header capture, pixel assembly and output strobes
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    sig_d      = sig_q;
    offset_d   = offset_q;
    width_d    = width_q;
    height_d   = height_q;
    bpp_d      = bpp_q;
    comp_d     = comp_q;
    phase_d    = phase_q;
    pad_cnt_d  = pad_cnt_q;
    b_d        = b_q;
    g_d        = g_q;
    col_d      = col_q;
    row_cnt_d  = row_cnt_q;
    row_base_d = row_base_q;
    topdown_d  = topdown_q;
    pix_we_d   = 1'b0;
    pix_addr_d = pix_addr_q;
    pix_data_d = pix_data_q;
    hdr_ok_d   = hdr_ok_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    case (state_q)
      S_HDR: if (in_valid) begin
        byte_cnt_d = byte_cnt_q + 32'd1;
        // Fields are little-endian: shift each new byte in from the top.
        if (byte_cnt_q <= 32'd1)                          sig_d    = {in_byte, sig_q[15:8]};
        if (byte_cnt_q >= 32'd10 && byte_cnt_q <= 32'd13) offset_d = {in_byte, offset_q[31:8]};
        if (byte_cnt_q >= 32'd18 && byte_cnt_q <= 32'd21) width_d  = {in_byte, width_q[31:8]};
        if (byte_cnt_q >= 32'd22 && byte_cnt_q <= 32'd25) height_d = {in_byte, height_q[31:8]};
        if (byte_cnt_q >= 32'd28 && byte_cnt_q <= 32'd29) bpp_d    = {in_byte, bpp_q[15:8]};
        if (byte_cnt_q >= 32'd30 && byte_cnt_q <= 32'd33) comp_d   = {in_byte, comp_q[31:8]};
        if (byte_cnt_q == 32'd53) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_ERR;
        err_d   = 1'b1;
        if (sig_q != 16'h4D42)                              err_code_d = 3'd1;
        else if (width_q != 32'(H_ACTIVE) || !height_ok)    err_code_d = 3'd2;
        else if (bpp_q != 16'd24)                           err_code_d = 3'd3;
        else if (comp_q != 32'd0)                           err_code_d = 3'd4;
        else if (offset_q < 32'd54 || offset_q > 32'd65535) err_code_d = 3'd5;
        else begin
          err_d      = 1'b0;
          hdr_ok_d   = 1'b1;
          topdown_d  = height_q[31];
          row_base_d = height_q[31] ? '0 : BASE_BOTTOM;
          state_d    = (offset_q > 32'd54) ? S_SKIP : S_PIX;
        end
      end
      S_SKIP: if (in_valid) begin
        byte_cnt_d = byte_cnt_q + 32'd1;
        if (byte_cnt_d == offset_q) state_d = S_PIX;
      end
      S_PIX: if (in_valid) begin
        case (phase_q)
          2'd0: begin b_d = in_byte; phase_d = 2'd1; end
          2'd1: begin g_d = in_byte; phase_d = 2'd2; end
          default: begin
            phase_d    = 2'd0;
            pix_we_d   = 1'b1;
            pix_data_d = {in_byte, g_q, b_q};
            pix_addr_d = row_base_q + col_q;
            if (col_q == COL_LAST) begin
              col_d     = '0;
              row_cnt_d = row_cnt_q + 1'b1;
`ifdef BMP_TOPDOWN_EN
              row_base_d = topdown_q ? row_base_q + H_STEP : row_base_q - H_STEP;
`else
              row_base_d = row_base_q - H_STEP;
`endif
              if (row_cnt_q == ROW_LAST) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else if (HAS_PAD) begin
                state_d   = S_PAD;
                pad_cnt_d = 2'd0;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        endcase
      end
      S_PAD: if (in_valid) begin
        if (pad_cnt_q == PAD_LAST) begin
          state_d   = S_PIX;
          pad_cnt_d = 2'd0;
        end else begin
          pad_cnt_d = pad_cnt_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_HDR;
      byte_cnt_q <= '0;
      sig_q      <= '0;
      offset_q   <= '0;
      width_q    <= '0;
      height_q   <= '0;
      bpp_q      <= '0;
      comp_q     <= '0;
      phase_q    <= '0;
      pad_cnt_q  <= '0;
      b_q        <= '0;
      g_q        <= '0;
      col_q      <= '0;
      row_cnt_q  <= '0;
      row_base_q <= '0;
      topdown_q  <= 1'b0;
      pix_we_q   <= 1'b0;
      pix_addr_q <= '0;
      pix_data_q <= '0;
      hdr_ok_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      sig_q      <= sig_d;
      offset_q   <= offset_d;
      width_q    <= width_d;
      height_q   <= height_d;
      bpp_q      <= bpp_d;
      comp_q     <= comp_d;
      phase_q    <= phase_d;
      pad_cnt_q  <= pad_cnt_d;
      b_q        <= b_d;
      g_q        <= g_d;
      col_q      <= col_d;
      row_cnt_q  <= row_cnt_d;
      row_base_q <= row_base_d;
      topdown_q  <= topdown_d;
      pix_we_q   <= pix_we_d;
      pix_addr_q <= pix_addr_d;
      pix_data_q <= pix_data_d;
      hdr_ok_q   <= hdr_ok_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign pix_we   = pix_we_q;
  assign pix_addr = pix_addr_q;
  assign pix_data = pix_data_q;
  assign hdr_ok   = hdr_ok_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_bmp_stream_parser.sv
// Scoreboard bench for bmp_stream_parser on a 5x2 image (one pad byte per row).
module tb_bmp_stream_parser;
  localparam int H = 5;
  localparam int V = 2;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rstn, in_valid;
  logic [7:0] in_byte;
  logic pix_we, hdr_ok, done, err;
  logic [AW-1:0] pix_addr;
  logic [23:0] pix_data;
  logic [2:0] err_code;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [23:0]   data;
    logic          last;
  } exp_t;

  typedef struct {
    logic [15:0] sig;
    logic [31:0] off, wid, hgt;
    logic [15:0] bpp;
    logic [31:0] comp;
    logic [2:0]  code;
  } bad_t;

  exp_t expq[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  bit gaps = 1'b0;

  always #10 clk = ~clk;

  bmp_stream_parser #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_byte(in_byte),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .hdr_ok(hdr_ok), .done(done), .err(err), .err_code(err_code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (pix_we === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h", pix_addr, pix_data);
      end else begin
        e = expq.pop_front();
        chk("pix_addr", 32'(pix_addr), 32'(e.addr));
        chk("pix_data", 32'(pix_data), 32'(e.data));
        chk("done_with_we", 32'(done), 32'(e.last));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    in_valid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [15:0] sig, input logic [31:0] off, input logic [31:0] wid,
                          input logic [31:0] hgt, input logic [15:0] bpp, input logic [31:0] comp);
    logic [7:0] h[54];
    for (int i = 0; i < 54; i++) h[i] = 8'h00;
    h[2] = 8'h5A; h[14] = 8'd40; h[26] = 8'd1;
    h[0] = sig[7:0]; h[1] = sig[15:8];
    for (int i = 0; i < 4; i++) begin
      h[10 + i] = off[8*i +: 8];
      h[18 + i] = wid[8*i +: 8];
      h[22 + i] = hgt[8*i +: 8];
      h[30 + i] = comp[8*i +: 8];
    end
    h[28] = bpp[7:0]; h[29] = bpp[15:8];
    for (int i = 0; i < 54; i++) send_byte(h[i]);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Skip bytes, then npix pixels (with a pad byte after each row); expected writes
  // are pushed just before their R byte is driven.
  task automatic send_body(input int off, input int npix, input bit topdown, input bit push);
    exp_t x;
    int r, c;
    for (int i = 54; i < off; i++) send_byte(8'hEE);
    for (int p = 0; p < npix; p++) begin
      r = p / H;
      c = p % H;
      x.addr = topdown ? AW'(r * H + c) : AW'((V - 1 - r) * H + c);
      x.data = {8'(p * 7 + 3), 8'(p * 7 + 2), 8'(p * 7 + 1)};
      x.last = (p == H * V - 1);
      send_byte(8'(p * 7 + 1));
      send_byte(8'(p * 7 + 2));
      if (push) expq.push_back(x);
      send_byte(8'(p * 7 + 3));
      if (c == H - 1) send_byte(8'hAA);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
    chk("drain_queue_empty", 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  task automatic flags(input string tag, input bit ok, input bit dn, input bit er, input logic [2:0] code);
    chk({tag, "_hdr_ok"}, 32'(hdr_ok), 32'(ok));
    chk({tag, "_done"}, 32'(done), 32'(dn));
    chk({tag, "_err"}, 32'(err), 32'(er));
    chk({tag, "_err_code"}, 32'(err_code), 32'(code));
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk({tag, "_pix_we"}, 32'(pix_we), 32'd0);
    chk({tag, "_pix_addr"}, 32'(pix_addr), 32'd0);
    chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    flags(tag, 1'b0, 1'b0, 1'b0, 3'd0);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  bad_t bad[8];

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    repeat (2) @(negedge clk);
    do_reset("reset");

    // Valid file, offset 58: four skipped bytes, writes 5..9 then 0..4
    send_hdr(16'h4D42, 32'd58, 32'(H), 32'(V), 16'd24, 32'd0);
    flags("hdr58", 1'b1, 1'b0, 1'b0, 3'd0);
    send_body(58, H * V, 1'b0, 1'b1);
    drain();
    flags("done58", 1'b1, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 6; i++) send_byte(8'h11);
    repeat (2) @(negedge clk);
    flags("after_done", 1'b1, 1'b1, 1'b0, 3'd0);

    // Valid file, offset 54, input stalls
    do_reset("reset2");
    gaps = 1'b1;
    send_hdr(16'h4D42, 32'd54, 32'(H), 32'(V), 16'd24, 32'd0);
    flags("hdr54", 1'b1, 1'b0, 1'b0, 3'd0);
    send_body(54, H * V, 1'b0, 1'b1);
    drain();
    flags("done54", 1'b1, 1'b1, 1'b0, 3'd0);
    gaps = 1'b0;

    // Rejected headers: no writes may follow
    bad[0] = '{16'h5842, 32'd54, 32'(H), 32'(V), 16'd24, 32'd0, 3'd1};
    bad[1] = '{16'h4D42, 32'd54, 32'(H), 32'(V), 16'd32, 32'd0, 3'd3};
    bad[2] = '{16'h4D42, 32'd54, 32'(H + 1), 32'(V), 16'd24, 32'd0, 3'd2};
    bad[3] = '{16'h5842, 32'd54, 32'(H), 32'(V), 16'd32, 32'd0, 3'd1};
    bad[4] = '{16'h4D42, 32'd54, 32'(H), 32'(V), 16'd24, 32'd1, 3'd4};
    bad[5] = '{16'h4D42, 32'd53, 32'(H), 32'(V), 16'd24, 32'd0, 3'd5};
    bad[6] = '{16'h4D42, 32'd65536, 32'(H), 32'(V), 16'd24, 32'd0, 3'd5};
    bad[7] = '{16'h4D42, 32'd54, 32'(H), 32'(V + 1), 16'd24, 32'd0, 3'd2};
    for (int k = 0; k < 8; k++) begin
      do_reset("reset_bad");
      send_hdr(bad[k].sig, bad[k].off, bad[k].wid, bad[k].hgt, bad[k].bpp, bad[k].comp);
      flags($sformatf("bad%0d", k), 1'b0, 1'b0, 1'b1, bad[k].code);
      send_body(54, H * V, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      flags($sformatf("bad%0d_after", k), 1'b0, 1'b0, 1'b1, bad[k].code);
    end

    // Reset mid-frame after three pixels, then a fresh file from byte 0
    do_reset("reset3");
    send_hdr(16'h4D42, 32'd54, 32'(H), 32'(V), 16'd24, 32'd0);
    send_body(54, 3, 1'b0, 1'b1);
    drain();
    do_reset("midreset");
    send_hdr(16'h4D42, 32'd54, 32'(H), 32'(V), 16'd24, 32'd0);
    flags("fresh_hdr", 1'b1, 1'b0, 1'b0, 3'd0);
    send_body(54, H * V, 1'b0, 1'b1);
    drain();
    flags("fresh_done", 1'b1, 1'b1, 1'b0, 3'd0);

    // Negative height
    do_reset("reset4");
    send_hdr(16'h4D42, 32'd54, 32'(H), 32'(-V), 16'd24, 32'd0);
`ifdef BMP_TOPDOWN_EN
    flags("topdown_hdr", 1'b1, 1'b0, 1'b0, 3'd0);
    send_body(54, H * V, 1'b1, 1'b1);
    drain();
    flags("topdown_done", 1'b1, 1'b1, 1'b0, 3'd0);
`else
    flags("neg_height", 1'b0, 1'b0, 1'b1, 3'd2);
    send_body(54, H * V, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    flags("neg_height_after", 1'b0, 1'b0, 1'b1, 3'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bmp_stream_parser.md
Name: bmp_stream_parser

Overview:
- Sits between sd_file_reader (byte stream outen/outbyte) and the 24-bit framebuffer write port feeding the HDMI scan-out.
- Parses and validates the BMP header, skips to the pixel-data offset, and assembles B,G,R bytes into 24-bit pixels.
- Strips row padding and converts BMP row order into raster framebuffer addresses (row 0 = top).

Parameters:
H_ACTIVE, 640, required image width in pixels (header must match)
V_ACTIVE, 480, required image height in pixels (absolute value must match)
ADDR_WIDTH, 19, framebuffer address width; must satisfy 2^ADDR_WIDTH >= H_ACTIVE*V_ACTIVE

Ports:
clk  input  1  system clock, 50 MHz
rstn  input  1  synchronous active-low reset
in_valid  input  1  one byte accepted per cycle when high (driven by outen & file_found)
in_byte  input  8  file byte, in file order
pix_we  output  1  framebuffer write strobe, one cycle per pixel
pix_addr  output  ADDR_WIDTH  framebuffer address = row*H_ACTIVE + col
pix_data  output  24  {R,G,B}
hdr_ok  output  1  header validated; stays high until reset
done  output  1  last pixel written; sticky
err  output  1  header rejected; sticky
err_code  output  3  0 none, 1 signature, 2 dimensions, 3 bpp, 4 compression, 5 offset

Behaviour:
- Reset is synchronous: on clk rising edge with rstn=0, all outputs go to 0, FSM goes to S_HDR, and all counters clear. Reset mid-stream aborts the frame; the next accepted byte is treated as file byte 0.
- byte_cnt is 32-bit and increments on every in_valid cycle in S_HDR and S_SKIP.
- S_HDR: captures bytes 0..53, multi-byte fields little-endian.
  - sig = bytes 0-1
  - offset = bytes 10-13
  - width = bytes 18-21
  - height = bytes 22-25 (signed)
  - bpp = bytes 28-29
  - comp = bytes 30-33
  - After byte 53, go to S_CHECK.
- S_CHECK: one cycle, no byte consumed; in_valid must be low here (the SD reader never produces back-to-back 55 bytes without a gap; a bench must leave at least one gap). Checks in priority order; the first failure sets err, err_code, and goes to S_ERR:
  - sig != 0x4D42 -> 1
  - width != H_ACTIVE, or |height| != V_ACTIVE -> 2
  - bpp != 24 -> 3
  - comp != 0 -> 4
  - offset < 54 or offset > 65535 -> 5
  - Pass: set hdr_ok; go to S_SKIP if offset > 54, else S_PIX.
- S_SKIP: discards bytes until byte_cnt == offset, then goes to S_PIX.
- S_PIX:
  - phase counter 0/1/2 stores B, G, R.
  - On the R byte: pix_data={R,G,B} and pix_we=1 on the next cycle (latency 1 cycle from the R byte); pix_addr = row_base + col; col increments.
  - When col reaches H_ACTIVE-1 on a write: col=0, row_cnt increments, row_base is updated, and the FSM enters S_PAD if pad != 0.
- pad = (4 - (3*H_ACTIVE mod 4)) mod 4, computed at elaboration. H=640 gives pad 0.
- S_PAD: discards exactly pad bytes, then returns to S_PIX.
- Row order:
  - Positive height (bottom-up): row_base starts at (V_ACTIVE-1)*H_ACTIVE and is decremented by H_ACTIVE each row.
  - Top-down case: see Optional Feature.
  - No multipliers; add/subtract only.
- After the last pixel's write (row_cnt == V_ACTIVE), go to S_DONE and set done in the same cycle as the final pix_we.
- S_DONE and S_ERR are terminal until reset; further bytes are ignored and pix_we stays 0.
- in_valid low stalls all states except S_CHECK; no state changes without an accepted byte.

Optional Feature:
- Macro BMP_TOPDOWN_EN.
- Defined: negative height equal to -V_ACTIVE is accepted. row_base starts at 0 and is incremented by H_ACTIVE each row.
- Undefined: any negative height gives err_code 2. Only bottom-up files are supported, which saves the incrementing adder path and the sign handling.

Test Plan:
- Valid 640x480 header (offset 54, +480, bpp 24, comp 0), then 921600 pixel bytes -> hdr_ok after byte 53. First pix_we: addr 306560 (479*640), data {R,G,B} of bytes 56,55,54. Last write: addr 639, with done=1 in that cycle. Exactly 307200 writes in total.
- Bytes 0-1 = 'B','X', all else valid -> err=1, err_code=1; no pix_we ever; hdr_ok=0.
- H_ACTIVE=5, V_ACTIVE=2, offset 58 -> bytes 54-57 skipped. Each 15-byte row is followed by 1 pad byte that is skipped. Writes go to addrs 5..9, then 0..4; done after 10 writes.
- Valid header with bpp=32 -> err_code 3. Same header with width 641 -> err_code 2. bpp=32 plus a bad signature -> err_code 1 (priority).
- rstn asserted low for 1 cycle after pixel 1000 -> all outputs 0 on the next cycle. A fresh valid file streamed afterwards parses from byte 0, and the first write goes to addr 306560.
- With BMP_TOPDOWN_EN, height=-480 -> first write addr 0, last addr 307199. Without the macro, the same file -> err_code 2.
